fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch sequencer (IDLE -> FETCH -> UPDATE).
//
// Handles one instruction at a time. In FETCH it holds a read request at the
// current PC until the memory acknowledges, and captures the returned word into
// IR. In UPDATE it pulses the active-low PC load strobe with either PC+AddrInc
// or a pending branch target. All outputs are registered.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a FETCH wait limit. When
// TimeoutCycles FETCH cycles pass without MemAck, the sticky Fault flag is set
// and the block parks in IDLE until reset. Without the macro, Fault is tied to
// 0 and FETCH waits indefinitely.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        request continuous fetching while high
//   stall_i        blocks the start of a new fetch while high
//   branch_i       redirect the PC to branch_addr_i
//   branch_addr_i  redirect target
//   pc_i           current PC (PC register output)
//   pc_next_o      next PC (PC register input)
//   pcld_n_o       active-low PC register load strobe
//   mem_req_o      instruction memory read request
//   mem_addr_o     read address
//   mem_ack_i      read data valid
//   mem_data_i     read data
//   ir_o           instruction register
//   ir_valid_o     one-cycle pulse, ir_o holds a new instruction
//   busy_o         high while the state is not IDLE
//   fault_o        sticky fetch-timeout flag
module fetch_ctrl #(
   parameter int unsigned DataWidth     = 16,
   parameter int unsigned AddrInc       = 1,
   parameter int unsigned TimeoutCycles = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 stall_i,
   input  logic                 branch_i,
   input  logic [DataWidth-1:0] branch_addr_i,
   input  logic [DataWidth-1:0] pc_i,
   output logic [DataWidth-1:0] pc_next_o,
   output logic                 pcld_n_o,
   output logic                 mem_req_o,
   output logic [DataWidth-1:0] mem_addr_o,
   input  logic                 mem_ack_i,
   input  logic [DataWidth-1:0] mem_data_i,
   output logic [DataWidth-1:0] ir_o,
   output logic                 ir_valid_o,
   output logic                 busy_o,
   output logic                 fault_o
);

   typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] pc_next_q, pc_next_d;
   logic                 pcld_n_q, pcld_n_d;
   logic                 mem_req_q, mem_req_d;
   logic [DataWidth-1:0] mem_addr_q, mem_addr_d;
   logic [DataWidth-1:0] ir_q, ir_d;
   logic                 ir_valid_q, ir_valid_d;
   logic                 busy_q, busy_d;
   logic                 br_pend_q, br_pend_d;
   logic [DataWidth-1:0] br_addr_q, br_addr_d;
   logic [DataWidth-1:0] fetch_addr;
   logic                 fault_blk;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned     TmoW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            fault_q, fault_d;

   assign fault_blk = fault_q;
   assign fault_o   = fault_q;
`else
   assign fault_blk = 1'b0;
   assign fault_o   = 1'b0;
`endif

   // A PC load issued in the current cycle has not reached pc_i yet, so a fetch
   // starting now must use the value being loaded instead of the stale PC.
   assign fetch_addr = pcld_n_q ? pc_i : pc_next_q;

   always_comb begin
      state_d    = state_q;
      pc_next_d  = pc_next_q;
      pcld_n_d   = 1'b1;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
      br_pend_d  = br_pend_q;
      br_addr_d  = br_addr_q;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      fault_d    = fault_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (branch_i) begin
               pc_next_d = branch_addr_i;
               pcld_n_d  = 1'b0;
            end else if (start_i && !stall_i && !fault_blk) begin
               state_d    = FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr;
            end
         end

         FETCH: begin
            // Latest branch seen during the fetch wins.
            if (branch_i) begin
               br_pend_d = 1'b1;
               br_addr_d = branch_addr_i;
            end
            if (mem_ack_i) begin
               state_d   = UPDATE;
               ir_d      = mem_data_i;
               mem_req_d = 1'b0;
               pcld_n_d  = 1'b0;
               br_pend_d = 1'b0;
               // A branch pending or arriving with the ack squashes the instruction.
               if (branch_i) begin
                  pc_next_d = branch_addr_i;
               end else if (br_pend_q) begin
                  pc_next_d = br_addr_q;
               end else begin
                  pc_next_d  = pc_i + DataWidth'(AddrInc);
                  ir_valid_d = 1'b1;
               end
`ifdef FETCH_TIMEOUT_EN
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TmoLast) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               br_pend_d = 1'b0;
               fault_d   = 1'b1;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            end
         end

         UPDATE: begin
            // A late redirect reloads the PC and parks in IDLE, as Branch does there.
            if (branch_i) begin
               state_d   = IDLE;
               pc_next_d = branch_addr_i;
               pcld_n_d  = 1'b0;
            end else if (start_i && !stall_i) begin
               state_d    = FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         pc_next_q  <= '0;
         pcld_n_q   <= 1'b1;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         br_pend_q  <= 1'b0;
         br_addr_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_next_q  <= pc_next_d;
         pcld_n_q   <= pcld_n_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         busy_q     <= busy_d;
         br_pend_q  <= br_pend_d;
         br_addr_q  <= br_addr_d;
`ifdef FETCH_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         fault_q    <= fault_d;
`endif
      end
   end

   assign pc_next_o  = pc_next_q;
   assign pcld_n_o   = pcld_n_q;
   assign mem_req_o  = mem_req_q;
   assign mem_addr_o = mem_addr_q;
   assign ir_o       = ir_q;
   assign ir_valid_o = ir_valid_q;
   assign busy_o     = busy_q;

endmodule
